if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 34 +++
 rtl/if_stage.sv | 137 +++++++++++++
 tb/tb_if_stage.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if : instruction-memory read channel used by the fetch stage.
//
// Handshake: the fetch stage raises imem_req and holds imem_addr stable for
// as long as it waits. The memory answers by raising imem_ack for exactly the
// cycle in which imem_rdata carries the word for imem_addr. imem_ack outside
// a request cycle carries no meaning and is ignored by the fetch stage.
//
// Signals
//   imem_req   : fetch -> mem, read request (registered in the fetch stage)
//   imem_addr  : fetch -> mem, word address, always equal to the fetch pc
//   imem_ack   : mem -> fetch, imem_rdata is valid this cycle
//   imem_rdata : mem -> fetch, instruction word
// ---------------------------------------------------------------------------
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction fetch stage with a three-state request FSM.
//
// IDLE -> REQ -> VALID -> REQ -> ... ; one instruction per two cycles at best.
// In REQ the stage requests imem_addr (= pc) until imem_ack, capturing
// imem_rdata into inst. In VALID it presents inst to decode; when decode is
// not stalling, the next pc is taken from pcsource (decoded from the held
// inst) and the fetch count is bumped.
//
// Ports
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   pcsource          : next-pc select 00 pc+4, 01 bpc, 10 rpc, 11 jpc
//   bpc, rpc, jpc     : branch / register-jump / absolute-jump targets
//   stall             : decode not ready, hold the presented instruction
//   imem              : instruction-memory channel (master side)
//   inst, inst_valid  : registered instruction and its valid flag
//   pc, pc4           : fetch address and pc + 4
//   fetch_count       : number of instructions consumed by decode
//   count_load        : debug preload strobe for fetch_count
//   count_load_value  : value written into fetch_count on count_load
//   fsm_state         : debug view of the FSM (0 IDLE, 1 REQ, 2 VALID)
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         pcsource,
    input  logic [31:0]        bpc,
    input  logic [31:0]        rpc,
    input  logic [31:0]        jpc,
    input  logic               stall,
    if_stage_if.master         imem,
    output logic [31:0]        inst,
    output logic               inst_valid,
    output logic [31:0]        pc,
    output logic [31:0]        pc4,
    output logic [31:0]        fetch_count,
    input  logic               count_load,
    input  logic [31:0]        count_load_value,
    output logic [1:0]         fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } state_t;

    // Word alignment: the two low address bits never reach the pc register.
    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_ALN = RESET_PC & ALIGN_MASK;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        inst_valid_q;
    logic        imem_req_q;
    logic [31:0] fetch_count_q;

    logic [31:0] pc4_d;
    logic [31:0] target_d;
    logic [31:0] next_pc_d;

    // pc + 4 wraps naturally in 32 bits.
    assign pc4_d = pc_q + 32'd4;

    always_comb begin
        target_d = pc4_d;
        unique case (pcsource)
            2'b00:   target_d = pc4_d;
            2'b01:   target_d = bpc;
            2'b10:   target_d = rpc;
            2'b11:   target_d = jpc;
            default: target_d = pc4_d;
        endcase
        next_pc_d = target_d & ALIGN_MASK;
    end

    // Single FSM block; imem_req and inst_valid are registered alongside the
    // state so neither ever depends combinationally on imem_ack or stall.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC_ALN;
            inst_q        <= 32'h0;
            inst_valid_q  <= 1'b0;
            imem_req_q    <= 1'b0;
            fetch_count_q <= 32'h0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_q    <= REQ;
                    imem_req_q <= 1'b1;
                end
                REQ: begin
                    // stall is deliberately not looked at here.
                    if (imem.imem_ack) begin
                        inst_q       <= imem.imem_rdata;
                        state_q      <= VALID;
                        imem_req_q   <= 1'b0;
                        inst_valid_q <= 1'b1;
                    end
                end
                VALID: begin
                    if (!stall) begin
                        pc_q          <= next_pc_d;
                        fetch_count_q <= fetch_count_q + 32'd1;
                        state_q       <= REQ;
                        imem_req_q    <= 1'b1;
                        inst_valid_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    imem_req_q   <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
            endcase

            // Debug preload takes priority over the consume increment.
            if (count_load) begin
                fetch_count_q <= count_load_value;
            end
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = pc_q;
    assign inst           = inst_q;
    assign inst_valid     = inst_valid_q;
    assign pc             = pc_q;
    assign pc4            = pc4_d;
    assign fetch_count    = fetch_count_q;
    assign fsm_state      = state_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;

  logic clk;
  logic reset;
  logic [1:0] pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic stall;
  logic [31:0] inst;
  logic inst_valid;
  logic [31:0] pc, pc4, fetch_count;
  logic count_load;
  logic [31:0] count_load_value;
  logic [1:0] fsm_state;

  if_stage_if imem ();

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clock(clk),
    .reset(reset),
    .pcsource(pcsource),
    .bpc(bpc),
    .rpc(rpc),
    .jpc(jpc),
    .stall(stall),
    .imem(imem),
    .inst(inst),
    .inst_valid(inst_valid),
    .pc(pc),
    .pc4(pc4),
    .fetch_count(fetch_count),
    .count_load(count_load),
    .count_load_value(count_load_value),
    .fsm_state(fsm_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [31:0] exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_addr"}, imem.imem_addr, m_pc);
    chk({tag, "_pc4"}, pc4, m_pc + 32'd4);
    chk({tag, "_cnt"}, fetch_count, m_cnt);
  endtask

  // In REQ: withhold ack for 'waits' cycles (stall toggled, no effect), then ack.
  task automatic fetch(input logic [31:0] data, input int waits);
    for (int i = 0; i < waits; i++) begin
      imem.imem_ack = 1'b0;
      stall = 1'(($urandom_range(0, 1)));
      step();
      chk("wait_state", 32'(fsm_state), 32'(S_REQ));
      chk("wait_req", 32'(imem.imem_req), 32'd1);
      chk("wait_valid", 32'(inst_valid), 32'd0);
      chk_held("wait");
    end
    stall = 1'b0;
    imem.imem_ack = 1'b1;
    imem.imem_rdata = data;
    exp_q.push_back(data);
    step();
    imem.imem_ack = 1'b0;
    imem.imem_rdata = $urandom();
    chk("fetch_state", 32'(fsm_state), 32'(S_VALID));
    chk("fetch_valid", 32'(inst_valid), 32'd1);
    chk("fetch_req", 32'(imem.imem_req), 32'd0);
    if (exp_q.size() != 0) chk("fetch_inst", inst, exp_q.pop_front());
    chk_held("fetch");
  endtask

  // In VALID: consume with the given pcsource; model computes the next pc.
  task automatic consume(input logic [1:0] ps);
    logic [31:0] tgt;
    pcsource = ps;
    stall = 1'b0;
    case (ps)
      2'b00: tgt = m_pc + 32'd4;
      2'b01: tgt = bpc;
      2'b10: tgt = rpc;
      default: tgt = jpc;
    endcase
    m_pc = {tgt[31:2], 2'b00};
    m_cnt = m_cnt + 32'd1;
    step();
    pcsource = 2'(($urandom_range(0, 3)));
    chk("cons_state", 32'(fsm_state), 32'(S_REQ));
    chk("cons_req", 32'(imem.imem_req), 32'd1);
    chk("cons_valid", 32'(inst_valid), 32'd0);
    chk_held("cons");
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(fsm_state), 32'(S_IDLE));
    chk({tag, "_pc"}, pc, RST_PC);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_req"}, 32'(imem.imem_req), 32'd0);
    chk({tag, "_cnt"}, fetch_count, 32'h0);
  endtask

  initial begin
    logic [31:0] held_inst;
    reset = 1'b1;
    pcsource = 2'b00;
    bpc = 32'h0;
    rpc = 32'h0;
    jpc = 32'h0;
    stall = 1'b0;
    count_load = 1'b0;
    count_load_value = 32'h0;
    imem.imem_ack = 1'b0;
    imem.imem_rdata = 32'h0;
    m_pc = RST_PC;
    m_cnt = 32'h0;

    // reset state
    step();
    step();
    chk_reset("rst");

    // release; IDLE first, ack during IDLE is ignored
    reset = 1'b0;
    imem.imem_ack = 1'b1;
    imem.imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("idle_state", 32'(fsm_state), 32'(S_IDLE));
    chk("idle_req", 32'(imem.imem_req), 32'd0);
    step();
    imem.imem_ack = 1'b0;
    chk("req1_state", 32'(fsm_state), 32'(S_REQ));
    chk("req1_req", 32'(imem.imem_req), 32'd1);
    chk("req1_addr", imem.imem_addr, RST_PC);
    chk("req1_valid", 32'(inst_valid), 32'd0);

    // first fetch, zero-wait ack
    fetch(32'h1234_5678, 0);

    // sequential stream: four consumes, zero-wait ack
    for (int i = 0; i < 4; i++) begin
      consume(2'b00);
      fetch($urandom(), 0);
    end
    chk("seq_cnt4", fetch_count, 32'd4);
    chk("seq_pc", pc, 32'h0000_0010);

    // branch / register / jump targets with low bits set
    bpc = 32'h0000_0103;
    consume(2'b01);
    chk("bpc_addr", imem.imem_addr, 32'h0000_0100);
    fetch($urandom(), 1);
    rpc = 32'h0000_0207;
    consume(2'b10);
    chk("rpc_addr", imem.imem_addr, 32'h0000_0204);
    fetch($urandom(), 2);
    jpc = 32'h0000_030A;
    consume(2'b11);
    chk("jpc_addr", imem.imem_addr, 32'h0000_0308);
    fetch(32'hCAFE_F00D, 0);

    // stall for 5 cycles with pcsource toggling and spurious acks
    held_inst = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      stall = 1'b1;
      pcsource = 2'(i % 4);
      imem.imem_ack = 1'b1;
      imem.imem_rdata = $urandom();
      step();
      chk("stall_state", 32'(fsm_state), 32'(S_VALID));
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_req", 32'(imem.imem_req), 32'd0);
      chk("stall_inst", inst, held_inst);
      chk_held("stall");
    end
    imem.imem_ack = 1'b0;
    consume(2'b00);
    chk("resume_addr", imem.imem_addr, 32'h0000_030C);
    fetch($urandom(), 0);

    // pc wrap and fetch_count wrap
    jpc = 32'hFFFF_FFFF;
    consume(2'b11);
    fetch($urandom(), 0);
    chk("top_pc", pc, 32'hFFFF_FFFC);
    chk("top_pc4", pc4, 32'h0000_0000);
    stall = 1'b1;
    count_load = 1'b1;
    count_load_value = 32'hFFFF_FFFF;
    step();
    count_load = 1'b0;
    m_cnt = 32'hFFFF_FFFF;
    chk("preset_cnt", fetch_count, 32'hFFFF_FFFF);
    consume(2'b00);
    chk("wrap_pc", pc, 32'h0000_0000);
    chk("wrap_cnt", fetch_count, 32'h0000_0000);

    // ack withheld 3 cycles, then reset coincident with ack
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_req", 32'(imem.imem_req), 32'd1);
    end
    imem.imem_ack = 1'b1;
    imem.imem_rdata = 32'hBAD0_BAD0;
    reset = 1'b1;
    #1;
    chk_reset("abort_async");
    step();
    chk_reset("abort_edge");
    reset = 1'b0;
    imem.imem_ack = 1'b0;
    m_pc = RST_PC;
    m_cnt = 32'h0;
    step();
    chk("post_state", 32'(fsm_state), 32'(S_REQ));
    chk("post_valid", 32'(inst_valid), 32'd0);
    chk("post_inst", inst, 32'h0);
    fetch(32'hA5A5_5A5A, 1);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
